// File: rtl/parking_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
// Shared constants and helpers for the multi-class parking manager.
//   CNT_W_DEF : default width of every count / vacancy value
//   HOUR_W    : width of the time-of-day hour (0..23)
//   sat_sub   : subtraction clamped at zero (vacancies never go negative)
// -----------------------------------------------------------------------------
package parking_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int HOUR_W    = 5;

    // Work in 32 bits so callers with any CNT_W can share one helper.
    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/parking_manager_mc_cap_sched.sv
// -----------------------------------------------------------------------------
// parking_cap_sched
// Combinational hour -> capacity schedule.
//   hour_i    : current hour 0..23
//   uni_cap_o : uni capacity for that hour (shrinks by STEP per hour from
//               SHIFT_HOUR, floored at UNI_MIN)
//   gen_cap_o : remaining physical spaces, TOTAL_CAP - uni_cap
// -----------------------------------------------------------------------------
module parking_cap_sched
    import parking_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int TOTAL_CAP  = 700,
    parameter int UNI_CAP    = 500,
    parameter int UNI_MIN    = 200,
    parameter int STEP       = 50,
    parameter int SHIFT_HOUR = 13
) (
    input  logic [HOUR_W-1:0] hour_i,
    output logic [CNT_W-1:0]  uni_cap_o,
    output logic [CNT_W-1:0]  gen_cap_o
);

    logic [31:0] reduce;
    logic [31:0] cap;

    always_comb begin
        reduce = 32'd0;
        cap    = 32'(UNI_CAP);
        if (32'(hour_i) >= 32'(SHIFT_HOUR)) begin
            reduce = 32'(STEP) * (32'(hour_i) - 32'(SHIFT_HOUR));
            // Compare the reduction against the headroom rather than
            // subtracting first, so the floor is hit without wrapping.
            if (reduce >= 32'(UNI_CAP - UNI_MIN)) cap = 32'(UNI_MIN);
            else                                  cap = 32'(UNI_CAP) - reduce;
        end
    end

    assign uni_cap_o = CNT_W'(cap);
    assign gen_cap_o = CNT_W'(sat_sub(32'(TOTAL_CAP), cap));

endmodule

// File: rtl/parking_manager_mc.sv
// -----------------------------------------------------------------------------
// parking_manager_mc
// Two-class (uni / general) parking-lot manager with an owned time-of-day
// clock. Uni capacity shrinks on an hourly schedule; freed spaces go to the
// general pool. Uni cars overflow into general spaces when uni is full.
//   clk, rst               : clock, synchronous active-high reset
//   start                  : enables time counting (events always accepted)
//   car_entered / is_uni_car_entered : single-cycle entry request + class
//   car_exited  / is_uni_car_exited  : single-cycle exit event + class
//   uni_car_parked, parked_car, uni_overflow : registered counts
//   uni_vacated_space, vacated_space         : free spaces (comb from regs)
//   uni_is_vacated_space, is_vacated_space   : non-zero vacancy flags
//   entry_ack, entry_reject, exit_err        : registered one-cycle pulses
//   clock_hour                               : current hour 0..23
// -----------------------------------------------------------------------------
module parking_manager_mc
    import parking_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEF,
    parameter int TOTAL_CAP      = 700,
    parameter int UNI_CAP        = 500,
    parameter int UNI_MIN        = 200,
    parameter int STEP           = 50,
    parameter int SHIFT_HOUR     = 13,
    parameter int START_HOUR     = 8,
    parameter int TICKS_PER_HOUR = 3600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              car_entered,
    input  logic              is_uni_car_entered,
    input  logic              car_exited,
    input  logic              is_uni_car_exited,
    output logic [CNT_W-1:0]  uni_car_parked,
    output logic [CNT_W-1:0]  parked_car,
    output logic [CNT_W-1:0]  uni_overflow,
    output logic [CNT_W-1:0]  uni_vacated_space,
    output logic [CNT_W-1:0]  vacated_space,
    output logic              uni_is_vacated_space,
    output logic              is_vacated_space,
    output logic              entry_ack,
    output logic              entry_reject,
    output logic              exit_err,
    output logic [HOUR_W-1:0] clock_hour
);

    localparam int TICK_W = (TICKS_PER_HOUR > 1) ? $clog2(TICKS_PER_HOUR) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_HOUR - 1);

    logic [CNT_W-1:0]  uni_q, uni_d;
    logic [CNT_W-1:0]  gen_q, gen_d;
    logic [CNT_W-1:0]  ovf_q, ovf_d;
    logic              ack_q, ack_d;
    logic              rej_q, rej_d;
    logic              err_q, err_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [HOUR_W-1:0] hour_q, hour_d;

    logic [CNT_W-1:0]  uni_cap, gen_cap;

    // Vacancy seen by the current registers and after this cycle's exit.
    logic [31:0] excess_q, excess_x;
    logic [31:0] uvac_x, gvac_x;

    parking_cap_sched #(
        .CNT_W      (CNT_W),
        .TOTAL_CAP  (TOTAL_CAP),
        .UNI_CAP    (UNI_CAP),
        .UNI_MIN    (UNI_MIN),
        .STEP       (STEP),
        .SHIFT_HOUR (SHIFT_HOUR)
    ) u_sched (
        .hour_i    (hour_q),
        .uni_cap_o (uni_cap),
        .gen_cap_o (gen_cap)
    );

    // ---------------- registered state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            uni_q  <= '0;
            gen_q  <= '0;
            ovf_q  <= '0;
            ack_q  <= 1'b0;
            rej_q  <= 1'b0;
            err_q  <= 1'b0;
            tick_q <= '0;
            hour_q <= HOUR_W'(START_HOUR);
        end else begin
            uni_q  <= uni_d;
            gen_q  <= gen_d;
            ovf_q  <= ovf_d;
            ack_q  <= ack_d;
            rej_q  <= rej_d;
            err_q  <= err_d;
            tick_q <= tick_d;
            hour_q <= hour_d;
        end
    end

    // ---------------- time of day ----------------
    always_comb begin
        tick_d = tick_q;
        hour_d = hour_q;
        if (start) begin
            if (tick_q == TICK_LAST) begin
                tick_d = '0;
                hour_d = (hour_q == HOUR_W'(23)) ? '0 : hour_q + HOUR_W'(1);
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
    end

    // ---------------- events ----------------
    // Exit is resolved first; entry then sees the vacancy it freed. Both use
    // the capacity of the current (pre-tick) hour.
    always_comb begin
        uni_d    = uni_q;
        gen_d    = gen_q;
        ovf_d    = ovf_q;
        ack_d    = 1'b0;
        rej_d    = 1'b0;
        err_d    = 1'b0;

        if (car_exited) begin
            if (is_uni_car_exited) begin
                // Overflow cars leave first so general spaces are returned early.
                if (ovf_q != '0)      ovf_d = ovf_q - CNT_W'(1);
                else if (uni_q != '0) uni_d = uni_q - CNT_W'(1);
                else                  err_d = 1'b1;
            end else begin
                if (gen_q != '0) gen_d = gen_q - CNT_W'(1);
                else             err_d = 1'b1;
            end
        end

        uvac_x   = sat_sub(32'(uni_cap), 32'(uni_d));
        excess_x = sat_sub(32'(uni_d), 32'(uni_cap));
        gvac_x   = sat_sub(sat_sub(sat_sub(32'(gen_cap), 32'(gen_d)), 32'(ovf_d)), excess_x);

        if (car_entered) begin
            if (is_uni_car_entered) begin
                if (uvac_x != 32'd0) begin
                    uni_d = uni_d + CNT_W'(1);
                    ack_d = 1'b1;
                end else if (gvac_x != 32'd0) begin
                    ovf_d = ovf_d + CNT_W'(1);
                    ack_d = 1'b1;
                end else begin
                    rej_d = 1'b1;
                end
            end else begin
                if (gvac_x != 32'd0) begin
                    gen_d = gen_d + CNT_W'(1);
                    ack_d = 1'b1;
                end else begin
                    rej_d = 1'b1;
                end
            end
        end
    end

    // ---------------- outputs ----------------
    // Uni cars above a shrunken uni capacity stay parked and eat general space.
    assign excess_q = sat_sub(32'(uni_q), 32'(uni_cap));

    assign uni_vacated_space = CNT_W'(sat_sub(32'(uni_cap), 32'(uni_q)));
    assign vacated_space     = CNT_W'(sat_sub(sat_sub(sat_sub(32'(gen_cap), 32'(gen_q)),
                                                      32'(ovf_q)), excess_q));

    assign uni_is_vacated_space = (uni_vacated_space != '0);
    assign is_vacated_space     = (vacated_space != '0);

    assign uni_car_parked = uni_q;
    assign parked_car     = gen_q;
    assign uni_overflow   = ovf_q;
    assign entry_ack      = ack_q;
    assign entry_reject   = rej_q;
    assign exit_err       = err_q;
    assign clock_hour     = hour_q;

endmodule

// File: tb/tb_parking_manager_mc.sv
// -----------------------------------------------------------------------------
// tb_parking_manager_mc
// Scoreboard bench: each driven cycle pushes the model's expected outputs,
// which are popped and compared one cycle later (#1 after the edge).
// -----------------------------------------------------------------------------
module tb_parking_manager_mc;

    localparam int UC  = 4;
    localparam int TC  = 7;
    localparam int UM  = 2;
    localparam int ST  = 1;
    localparam int SH  = 9;
    localparam int H0  = 8;
    localparam int TPH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0, start = 1'b0;
    logic        ce = 1'b0, ceu = 1'b0, cx = 1'b0, cxu = 1'b0;
    logic [15:0] uni_car_parked, parked_car, uni_overflow;
    logic [15:0] uni_vacated_space, vacated_space;
    logic        uni_is_vacated_space, is_vacated_space;
    logic        entry_ack, entry_reject, exit_err;
    logic [4:0]  clock_hour;

    parking_manager_mc #(
        .CNT_W(16), .TOTAL_CAP(TC), .UNI_CAP(UC), .UNI_MIN(UM), .STEP(ST),
        .SHIFT_HOUR(SH), .START_HOUR(H0), .TICKS_PER_HOUR(TPH)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .car_entered(ce), .is_uni_car_entered(ceu),
        .car_exited(cx), .is_uni_car_exited(cxu),
        .uni_car_parked(uni_car_parked), .parked_car(parked_car),
        .uni_overflow(uni_overflow), .uni_vacated_space(uni_vacated_space),
        .vacated_space(vacated_space), .uni_is_vacated_space(uni_is_vacated_space),
        .is_vacated_space(is_vacated_space), .entry_ack(entry_ack),
        .entry_reject(entry_reject), .exit_err(exit_err), .clock_hour(clock_hour)
    );

    always #5 clk = ~clk;

    typedef struct {
        int uni, gen, ovf, uvac, gvac, ack, rej, err, hour;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_bad = 0;

    // Model state
    int m_uni = 0, m_gen = 0, m_ovf = 0, m_tick = 0, m_hour = H0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_ucap(input int h);
        int c;
        if (h < SH) return UC;
        c = UC - ST * (h - SH);
        return (c < UM) ? UM : c;
    endfunction

    function automatic int m_uvac(input int h, input int u);
        int v;
        v = m_ucap(h) - u;
        return (v > 0) ? v : 0;
    endfunction

    function automatic int m_gvac(input int h, input int u, input int g, input int o);
        int ex, v;
        ex = u - m_ucap(h);
        if (ex < 0) ex = 0;
        v = (TC - m_ucap(h)) - g - o - ex;
        return (v > 0) ? v : 0;
    endfunction

    // Drive one cycle, advance the model, compare after the edge.
    task automatic step(input bit r, input bit s, input bit e, input bit eu,
                        input bit x, input bit xu);
        exp_t ex, got;
        int ack, rej, err;
        rst = r; start = s; ce = e; ceu = eu; cx = x; cxu = xu;
        ack = 0; rej = 0; err = 0;
        if (r) begin
            m_uni = 0; m_gen = 0; m_ovf = 0; m_tick = 0; m_hour = H0;
        end else begin
            if (x) begin
                if (xu) begin
                    if (m_ovf > 0)      m_ovf--;
                    else if (m_uni > 0) m_uni--;
                    else                err = 1;
                end else begin
                    if (m_gen > 0) m_gen--;
                    else           err = 1;
                end
            end
            if (e) begin
                if (eu) begin
                    if (m_uvac(m_hour, m_uni) > 0) begin m_uni++; ack = 1; end
                    else if (m_gvac(m_hour, m_uni, m_gen, m_ovf) > 0) begin m_ovf++; ack = 1; end
                    else rej = 1;
                end else begin
                    if (m_gvac(m_hour, m_uni, m_gen, m_ovf) > 0) begin m_gen++; ack = 1; end
                    else rej = 1;
                end
            end
            if (s) begin
                if (m_tick == TPH - 1) begin
                    m_tick = 0;
                    m_hour = (m_hour == 23) ? 0 : m_hour + 1;
                end else begin
                    m_tick++;
                end
            end
        end
        ex.uni = m_uni; ex.gen = m_gen; ex.ovf = m_ovf;
        ex.uvac = m_uvac(m_hour, m_uni);
        ex.gvac = m_gvac(m_hour, m_uni, m_gen, m_ovf);
        ex.ack = ack; ex.rej = rej; ex.err = err; ex.hour = m_hour;
        q.push_back(ex);

        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            got = q.pop_front();
            chk("uni_car_parked", uni_car_parked, got.uni);
            chk("parked_car", parked_car, got.gen);
            chk("uni_overflow", uni_overflow, got.ovf);
            chk("uni_vacated_space", uni_vacated_space, got.uvac);
            chk("vacated_space", vacated_space, got.gvac);
            chk("uni_is_vacated_space", uni_is_vacated_space, got.uvac != 0);
            chk("is_vacated_space", is_vacated_space, got.gvac != 0);
            chk("entry_ack", entry_ack, got.ack);
            chk("entry_reject", entry_reject, got.rej);
            chk("exit_err", exit_err, got.err);
            chk("clock_hour", clock_hour, got.hour);
        end
    endtask

    initial begin
        // 1. reset state
        step(1, 0, 0, 0, 0, 0);
        chk("rst_hour", clock_hour, 8);
        chk("rst_uvac", uni_vacated_space, 4);
        chk("rst_vac", vacated_space, 3);
        chk("rst_flags", {uni_is_vacated_space, is_vacated_space}, 2'b11);

        // 2. general exit on empty lot
        step(0, 0, 0, 0, 1, 0);
        chk("empty_exit_err", exit_err, 1);
        chk("empty_exit_vac", vacated_space, 3);
        step(0, 0, 0, 0, 0, 0);
        chk("exit_err_drop", exit_err, 0);

        // 3. fill general, reject, exit+entry same cycle
        repeat (3) step(0, 0, 1, 0, 0, 0);
        chk("gen_full_cnt", parked_car, 3);
        chk("gen_full_vac", vacated_space, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("gen_reject", entry_reject, 1);
        chk("gen_reject_cnt", parked_car, 3);
        step(0, 0, 1, 0, 1, 0);
        chk("swap_ack", entry_ack, 1);
        chk("swap_cnt", parked_car, 3);

        // 4. uni fill, overflow, overflow-first exit
        step(1, 0, 0, 0, 0, 0);
        repeat (4) step(0, 0, 1, 1, 0, 0);
        chk("uni_full_uvac", uni_vacated_space, 0);
        step(0, 0, 1, 1, 0, 0);
        chk("ovf_ack", entry_ack, 1);
        chk("ovf_cnt", uni_overflow, 1);
        chk("ovf_vac", vacated_space, 2);
        step(0, 0, 0, 0, 1, 1);
        chk("ovf_exit_ovf", uni_overflow, 0);
        chk("ovf_exit_uni", uni_car_parked, 4);

        // 5. capacity schedule with uni full
        step(1, 0, 0, 0, 0, 0);
        repeat (4) step(0, 0, 1, 1, 0, 0);
        repeat (8) step(0, 1, 0, 0, 0, 0);
        chk("h10_hour", clock_hour, 10);
        chk("h10_uvac", uni_vacated_space, 0);
        chk("h10_vac", vacated_space, 3);
        repeat (8) step(0, 1, 0, 0, 0, 0);
        chk("h12_hour", clock_hour, 12);
        chk("h12_vac", vacated_space, 3);

        // 6. wrap 23 -> 0, then reset mid-count
        repeat (44) step(0, 1, 0, 0, 0, 0);
        chk("h23_hour", clock_hour, 23);
        repeat (4) step(0, 1, 0, 0, 0, 0);
        chk("wrap_hour", clock_hour, 0);
        chk("wrap_vac", vacated_space, 3);
        repeat (2) step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("midrst_hour", clock_hour, 8);
        chk("midrst_uni", uni_car_parked, 0);
        repeat (3) step(0, 1, 0, 0, 0, 0);
        chk("tick0_hold", clock_hour, 8);
        step(0, 1, 0, 0, 0, 0);
        chk("tick0_adv", clock_hour, 9);

        // Entry on the hour-change edge uses the old (larger) uni capacity.
        repeat (3) step(0, 1, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        chk("edge_hour", clock_hour, 10);
        chk("edge_uni", uni_car_parked, 4);
        chk("edge_ovf", uni_overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
